// File: rtl/cache_req_frontend_if.sv
// Request, response and cache-side bundle for cache_req_frontend.
// slave = the front-end itself, master = CPU/cache environment.
interface cache_req_frontend_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic        rsp_hit;
  logic [31:0] rsp_rdata;
  logic        cache_read_en;
  logic        cache_write_en;
  logic [31:0] cache_address;
  logic [31:0] cache_write_data;
  logic        cache_hit;
  logic [31:0] cache_read_data;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  rsp_ready, cache_hit, cache_read_data,
    output req_ready, rsp_valid, rsp_write, rsp_hit,
    output rsp_rdata, cache_read_en, cache_write_en,
    output cache_address, cache_write_data
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output rsp_ready, cache_hit, cache_read_data,
    input  req_ready, rsp_valid, rsp_write, rsp_hit,
    input  rsp_rdata, cache_read_en, cache_write_en,
    input  cache_address, cache_write_data
  );
endinterface

// File: rtl/cache_req_frontend.sv
// In-order request front-end for the 2-way word cache: FIFO, pend, 2-entry rsp buffer.
// Optional load-miss replay is built when CACHE_REPLAY_ON_MISS_EN is defined.
module cache_req_frontend #(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 2
) (
  input logic clk,
  input logic rst,
  cache_req_frontend_if.slave bus
);
  localparam int AW = $clog2(REQ_DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        fq_write_q [REQ_DEPTH];
  logic [31:0] fq_addr_q  [REQ_DEPTH];
  logic [31:0] fq_wdata_q [REQ_DEPTH];
  logic        full, empty, push, pop;
  logic        head_write;
  logic [31:0] head_addr, head_wdata;

  logic        rb_write_q [2];
  logic        rb_hit_q   [2];
  logic [31:0] rb_data_q  [2];
  logic        rb_wp_q, rb_rp_q;
  logic [1:0]  rsp_count_q;
  logic        drain, rsp_push;
  logic [31:0] push_data;

  logic        pend_valid_q, pend_write_q, pend_hit_q;
  logic        pend_miss;
  logic [2:0]  occ;
  logic        credit, fifo_issue, issue;
  logic        rpl_req, rpl_issue;
  logic [31:0] rpl_addr;

  assign empty = wr_ptr_q == rd_ptr_q;
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push  = bus.req_valid && !full;
  assign pop   = fifo_issue;
  assign bus.req_ready = !full;

  assign head_write = fq_write_q[rd_ptr_q[AW-1:0]];
  assign head_addr  = fq_addr_q[rd_ptr_q[AW-1:0]];
  assign head_wdata = fq_wdata_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fq_write_q[wr_ptr_q[AW-1:0]] <= bus.req_write;
      fq_addr_q[wr_ptr_q[AW-1:0]]  <= bus.req_addr;
      fq_wdata_q[wr_ptr_q[AW-1:0]] <= bus.req_wdata;
    end
  end

  // Slots held by pend + buffered responses, counting a same-cycle pop as free
  assign drain  = bus.rsp_valid && bus.rsp_ready;
  assign occ    = {1'b0, rsp_count_q} + {2'b0, pend_valid_q}
                - {2'b0, drain};
  assign credit = occ < 3'(RSP_DEPTH);

`ifdef CACHE_REPLAY_ON_MISS_EN
  typedef enum logic {S_RUN, S_REPLAY} state_e;
  state_e      state_q, state_d;
  logic [31:0] pend_addr_q, rpl_addr_q, rpl_addr_d;
  logic        pend_rpl_q, rpl_credit;

  assign pend_miss  = pend_valid_q && !pend_write_q &&
                      !pend_hit_q && !pend_rpl_q;
  // The replay reuses the slot of its own first access
  assign rpl_credit = (rsp_count_q - {1'b0, drain}) < 2'(RSP_DEPTH);
  assign rpl_issue  = rpl_req && rpl_credit;

  always_comb begin
    state_d    = state_q;
    rpl_addr_d = rpl_addr_q;
    rpl_req    = 1'b0;
    rpl_addr   = rpl_addr_q;
    unique case (state_q)
      S_RUN: begin
        if (pend_miss) begin
          rpl_req  = 1'b1;
          rpl_addr = pend_addr_q;
          if (!rpl_credit) begin
            state_d    = S_REPLAY;
            rpl_addr_d = pend_addr_q;
          end
        end
      end
      S_REPLAY: begin
        rpl_req = 1'b1;
        if (rpl_credit) state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      rpl_addr_q  <= '0;
      pend_addr_q <= '0;
      pend_rpl_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rpl_addr_q <= rpl_addr_d;
      if (issue) begin
        pend_addr_q <= bus.cache_address;
        pend_rpl_q  <= rpl_issue;
      end
    end
  end
`else
  assign pend_miss = 1'b0;
  assign rpl_req   = 1'b0;
  assign rpl_issue = 1'b0;
  assign rpl_addr  = '0;
`endif

  assign fifo_issue = !empty && credit && !rpl_req;
  assign issue      = fifo_issue || rpl_issue;

  assign bus.cache_read_en    = rpl_issue || (fifo_issue && !head_write);
  assign bus.cache_write_en   = fifo_issue && head_write;
  assign bus.cache_address    = rpl_issue ? rpl_addr : head_addr;
  assign bus.cache_write_data = head_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_write_q <= 1'b0;
      pend_hit_q   <= 1'b0;
    end else begin
      pend_valid_q <= issue;
      if (issue) begin
        pend_write_q <= bus.cache_write_en;
        pend_hit_q   <= bus.cache_hit && !rpl_issue;
      end
    end
  end

  assign rsp_push  = pend_valid_q && !pend_miss;
  assign push_data = pend_write_q ? '0 : bus.cache_read_data;

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rb_write_q[rb_wp_q] <= pend_write_q;
      rb_hit_q[rb_wp_q]   <= pend_hit_q;
      rb_data_q[rb_wp_q]  <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rb_wp_q     <= 1'b0;
      rb_rp_q     <= 1'b0;
      rsp_count_q <= '0;
    end else begin
      if (rsp_push) rb_wp_q <= !rb_wp_q;
      if (drain)    rb_rp_q <= !rb_rp_q;
      rsp_count_q <= rsp_count_q + {1'b0, rsp_push}
                   - {1'b0, drain};
    end
  end

  assign bus.rsp_valid = rsp_count_q != 2'd0;
  assign bus.rsp_write = bus.rsp_valid && rb_write_q[rb_rp_q];
  assign bus.rsp_hit   = bus.rsp_valid && rb_hit_q[rb_rp_q];
  assign bus.rsp_rdata = bus.rsp_valid ? rb_data_q[rb_rp_q] : '0;
endmodule

// File: tb/tb_cache_req_frontend.sv
// Directed bench for cache_req_frontend with a behavioural 2-way/16-set cache.
// Memory words read back as their own address on a fill.
module tb_cache_req_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cache_req_frontend_if bus();

  cache_req_frontend #(.REQ_DEPTH(4), .RSP_DEPTH(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

`ifdef CACHE_REPLAY_ON_MISS_EN
  localparam logic [31:0] MISS_100 = 32'h100;
  localparam logic [31:0] MISS_80  = 32'h80;
  localparam int          RD80     = 2;
`else
  localparam logic [31:0] MISS_100 = 32'h0;
  localparam logic [31:0] MISS_80  = 32'h0;
  localparam int          RD80     = 1;
`endif

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [25:0] ctag [16][2];
  logic        cvld [16][2];
  logic [31:0] cdat [16][2];
  logic        clru [16];
  logic [31:0] crd_q;
  logic [3:0]  cs;
  logic [25:0] ct;
  logic        ch0, ch1;

  always_comb begin
    cs  = bus.cache_address[5:2];
    ct  = bus.cache_address[31:6];
    ch0 = cvld[cs][0] && ctag[cs][0] == ct;
    ch1 = cvld[cs][1] && ctag[cs][1] == ct;
    bus.cache_hit = (bus.cache_read_en || bus.cache_write_en) && (ch0 || ch1);
  end
  assign bus.cache_read_data = crd_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < 16; s++) begin
        cvld[s][0] <= 1'b0;
        cvld[s][1] <= 1'b0;
        clru[s]    <= 1'b0;
      end
      crd_q <= '0;
    end else if (bus.cache_read_en || bus.cache_write_en) begin
      if (ch0 || ch1) begin
        if (bus.cache_write_en) cdat[cs][ch1] <= bus.cache_write_data;
        else crd_q <= cdat[cs][ch1];
        clru[cs] <= !ch1;
      end else begin
        cvld[cs][clru[cs]] <= 1'b1;
        ctag[cs][clru[cs]] <= ct;
        cdat[cs][clru[cs]] <= bus.cache_write_en ? bus.cache_write_data
                                                 : bus.cache_address;
        clru[cs] <= !clru[cs];
        if (bus.cache_read_en) crd_q <= '0;
      end
    end
  end

  logic        q_w [$];
  logic        q_h [$];
  logic [31:0] q_rd [$];
  int          q_c [$];
  int          acc_c [$];
  int          en_cnt = 0;
  int          rd80 = 0;
  int          both_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid && bus.rsp_ready) begin
        q_w.push_back(bus.rsp_write);
        q_h.push_back(bus.rsp_hit);
        q_rd.push_back(bus.rsp_rdata);
        q_c.push_back(cyc);
      end
      if (bus.cache_read_en || bus.cache_write_en) en_cnt++;
      if (bus.cache_read_en && bus.cache_write_en) both_cnt++;
      if (bus.cache_read_en && bus.cache_address == 32'h80) rd80++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic clr();
    q_w.delete();
    q_h.delete();
    q_rd.delete();
    q_c.delete();
    acc_c.delete();
    en_cnt = 0;
    rd80 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
  endtask

  task automatic send(input logic w, input logic [31:0] a,
                      input logic [31:0] d);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr  = a;
    bus.req_wdata = d;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", {31'd0, bus.req_ready}, 32'd1);
    acc_c.push_back(cyc);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    int k = 0;
    while (q_rd.size() < n && k < 300) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("n_rsp", q_rd.size(), n);
  endtask

  // Holds req_valid for 12 cycles, stepping the address on every accept
  task automatic stall_fill(input logic [31:0] base, output int n_acc);
    n_acc = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = base;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.req_ready) n_acc++;
      @(posedge clk);
      #1;
      bus.req_addr = base + 32'(4 * n_acc);
    end
    bus.req_valid = 1'b0;
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic        ew;
    logic        eh;
    logic [31:0] er;
    bit          lat;
  } vec_t;

  vec_t vt [12];

  initial begin
    int n_acc;
    int e0;
    vt[0]  = '{1'b1, 32'h40,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 1'b1};
    vt[1]  = '{1'b0, 32'h40,  32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vt[2]  = '{1'b1, 32'h44,  32'h11111111, 1'b1, 1'b0, 32'h0, 1'b1};
    vt[3]  = '{1'b1, 32'h48,  32'h22222222, 1'b1, 1'b0, 32'h0, 1'b1};
    vt[4]  = '{1'b1, 32'h4C,  32'h33333333, 1'b1, 1'b0, 32'h0, 1'b1};
    vt[5]  = '{1'b0, 32'h40,  32'h0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1};
    vt[6]  = '{1'b0, 32'h44,  32'h0, 1'b0, 1'b1, 32'h11111111, 1'b1};
    vt[7]  = '{1'b0, 32'h48,  32'h0, 1'b0, 1'b1, 32'h22222222, 1'b1};
    vt[8]  = '{1'b0, 32'h4C,  32'h0, 1'b0, 1'b1, 32'h33333333, 1'b1};
    vt[9]  = '{1'b1, 32'h40,  32'hCAFEF00D, 1'b1, 1'b1, 32'h0, 1'b1};
    vt[10] = '{1'b0, 32'h40,  32'h0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b1};
    vt[11] = '{1'b0, 32'h100, 32'h0, 1'b0, 1'b0, MISS_100, 1'b0};

    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_write", {31'd0, bus.rsp_write}, 32'd0);
    chk("rst_rsp_hit", {31'd0, bus.rsp_hit}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_en", {30'd0, bus.cache_read_en, bus.cache_write_en}, 32'd0);

    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(vt[i].w, vt[i].a, vt[i].d);
    wait_rsp(12);
    for (int i = 0; i < 12; i++) begin
      if (i < q_rd.size()) begin
        chk($sformatf("v%0d_write", i), {31'd0, q_w[i]}, {31'd0, vt[i].ew});
        chk($sformatf("v%0d_hit", i), {31'd0, q_h[i]}, {31'd0, vt[i].eh});
        chk($sformatf("v%0d_rdata", i), q_rd[i], vt[i].er);
        if (vt[i].lat)
          chk($sformatf("v%0d_latency", i), q_c[i] - acc_c[i], 32'd3);
        if (i >= 6 && i <= 8)
          chk($sformatf("v%0d_consec", i), q_c[i] - q_c[i-1], 32'd1);
      end
    end

    do_reset();
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++)
      send(1'b1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
    wait_rsp(6);
    clr();
    bus.rsp_ready = 1'b0;
    stall_fill(32'h200, n_acc);
    chk("bp_accepts", n_acc, 32'd6);
    e0 = en_cnt;
    repeat (5) @(negedge clk);
    chk("bp_ready_low", {31'd0, bus.req_ready}, 32'd0);
    chk("bp_no_enables", en_cnt - e0, 32'd0);
    chk("bp_no_pops", q_rd.size(), 32'd0);
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_pop_valid", {31'd0, bus.rsp_valid}, 32'd1);
    chk("bp_ready_at_pop", {31'd0, bus.req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_after_pop", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    wait_rsp(6);
    for (int i = 0; i < 6; i++) begin
      if (i < q_rd.size()) begin
        chk($sformatf("bp%0d_rdata", i), q_rd[i], 32'hA0 + 32'(i));
        chk($sformatf("bp%0d_hit", i), {31'd0, q_h[i]}, 32'd1);
      end
    end

    do_reset();
    bus.rsp_ready = 1'b1;
    send(1'b0, 32'h80, 32'h0);
    wait_rsp(1);
    repeat (3) @(posedge clk);
    #1;
    chk("miss_n_rsp", q_rd.size(), 32'd1);
    if (q_rd.size() > 0) begin
      chk("miss_hit", {31'd0, q_h[0]}, 32'd0);
      chk("miss_rdata", q_rd[0], MISS_80);
    end
    chk("miss_reads", rd80, RD80);

    do_reset();
    bus.rsp_ready = 1'b0;
    stall_fill(32'h300, n_acc);
    chk("rf_accepts", n_acc, 32'd6);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("rf_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rf_req_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("rf_en", {30'd0, bus.cache_read_en, bus.cache_write_en}, 32'd0);
    chk("rf_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clr();
    bus.rsp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rf_no_rsp", q_rd.size(), 32'd0);
    chk("rf_no_enables", en_cnt, 32'd0);
    chk("en_exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
